qpsk_tx_frame_ctrl: RTL and testbench
=====================================

Name: qpsk_tx_frame_ctrl

Overview:
- Frame sequencer in front of the QPSK data converter.
- On a start pulse it emits, over the converter's 32-bit AXI-Stream input:
  - PREAMBLE_LEN preamble words,
  - one length word,
  - payload_len payload words passed through from an upstream AXIS source.
- It then holds off for GUARD_CYCLES so the converter drains its last 16 symbols before the next frame.
- It owns framing and back-to-back frame spacing for the TX chain.

Parameters:
- PREAMBLE_WORD, 32'hCCCC_CCCC, constant word sent during the preamble (alternating symbol pattern).
- PREAMBLE_LEN, 4, number of preamble words; legal range 1..255.
- LEN_W, 8, width of payload_len in words; legal range 1..16.
- GUARD_CYCLES, 16, idle clocks after the last payload handshake; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- payload_len  in  LEN_W  payload word count; captured when start is accepted.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.
- axis_pl_tdata  in  32  payload source data.
- axis_pl_tvalid  in  1  payload source valid.
- axis_pl_tready  out  1  payload source ready.
- axis_out_tdata  out  32  to converter axis_in_tdata.
- axis_out_tvalid  out  1  to converter axis_in_tvalid.
- axis_out_tready  in  1  from converter axis_in_tready.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- While reset is high, on each edge: state=IDLE, counters=0, len_reg=0, done=0. busy, axis_out_tvalid and axis_pl_tready are therefore 0. axis_out_tdata=0 in IDLE.
- Reset asserted mid-frame aborts the frame: no done pulse, and the payload is not drained.
- FSM states: IDLE, PREAMBLE, LENGTH, PAYLOAD, GUARD. State and counters are registered; AXIS outputs are decoded combinationally from state.
- IDLE:
  - Outputs: tvalid=0, pl_tready=0.
  - If start=1: len_reg<=payload_len, cnt<=0, go to PREAMBLE.
- PREAMBLE:
  - Outputs: tdata=PREAMBLE_WORD, tvalid=1, pl_tready=0.
  - cnt increments on each out handshake (tvalid&&tready).
  - On the handshake with cnt==PREAMBLE_LEN-1: cnt<=0, go to LENGTH.
- LENGTH:
  - Outputs: tdata={8'h5A, 8'h00, 16-bit zero-extended len_reg}, tvalid=1.
  - On handshake: go to PAYLOAD if len_reg!=0, else go to GUARD with cnt<=0.
- PAYLOAD:
  - Pass-through: tdata=pl_tdata, tvalid=pl_tvalid, pl_tready=out_tready. This adds no latency and no bubbles.
  - cnt counts handshakes.
  - On the handshake with cnt==len_reg-1: cnt<=0, go to GUARD.
- GUARD:
  - Outputs: tvalid=0, pl_tready=0.
  - cnt increments every clock.
  - When cnt==GUARD_CYCLES-1: go to IDLE, done<=1 (done is high in the first IDLE cycle only).
- busy: equals (state!=IDLE). It rises the cycle after start is accepted and is low in the cycle done is high.
- A start during busy is ignored and not queued. A start in the same cycle done is high is accepted.
- AXIS rules:
  - While tvalid=1 and tready=0, tdata holds (constants in PREAMBLE/LENGTH; the source is responsible in PAYLOAD).
  - tvalid never deasserts without a handshake, except in PAYLOAD, where it mirrors the source.
- Counter widths: cnt width = max(8, LEN_W). len_reg compares are unsigned. payload_len of 2^LEN_W-1 must work without wrap.
- Source starvation in PAYLOAD (pl_tvalid=0) stalls indefinitely with no timeout.
- The converter deasserts tready for 15 of every 16 cycles; the controller must simply wait, with no word dropped or duplicated.

Test Plan:
- Basic frame, tready=1, payload_len=3, payload words 0x11111111/0x22222222/0x33333333 -> out sequence CCCCCCCC x4, 5A000003, 11111111, 22222222, 33333333; tvalid then low 16 clocks; done pulse 1 cycle; busy high for 4+1+3+16 cycles.
- payload_len=0 -> preamble x4, 5A000000, GUARD 16 clocks, done; axis_pl_tready never asserted.
- Converter-paced: tready high 1 cycle in 16 -> each word held stable until accepted; 8 words delivered in order, and tdata is unchanged across all stall cycles.
- Source stalls: pl_tvalid toggles 1/0 during PAYLOAD -> out_tvalid mirrors it, count is exact, GUARD entered only after the last handshake.
- start pulsed during PREAMBLE and again in the done cycle -> first ignored; second starts a new frame, PREAMBLE tvalid=1 the next cycle.
- reset asserted in PAYLOAD after 2 of 5 words -> next cycle IDLE, busy=0, tvalid=0, no done; the following start with len=1 produces a full correct frame.

Source files
------------

// File: rtl/qpsk_tx_frame_ctrl.sv
// rtl/qpsk_tx_frame_ctrl.sv - frame sequencer (preamble, length, payload, guard) feeding the QPSK converter
module qpsk_tx_frame_ctrl #(
    parameter logic [31:0] PREAMBLE_WORD = 32'hCCCC_CCCC,
    parameter int          PREAMBLE_LEN  = 4,
    parameter int          LEN_W         = 8,
    parameter int          GUARD_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] payload_len,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      axis_pl_tdata,
    input  logic             axis_pl_tvalid,
    output logic             axis_pl_tready,
    output logic [31:0]      axis_out_tdata,
    output logic             axis_out_tvalid,
    input  logic             axis_out_tready
);

    // Counter is wide enough for both the preamble/guard counts and the
    // largest payload length, so 2^LEN_W-1 words never wrap.
    localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_LENGTH,
        S_PAYLOAD,
        S_GUARD
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic               r_done;

    logic               w_out_hs;
    logic [CNT_W-1:0]   w_len_ext;
    logic [CNT_W-1:0]   w_pay_last;
    logic [31:0]        w_len_word;

    assign w_out_hs   = axis_out_tvalid && axis_out_tready;
    assign w_len_ext  = CNT_W'(r_len);
    // Only used in PAYLOAD, where r_len is known to be non-zero.
    assign w_pay_last = w_len_ext - CNT_W'(1);
    assign w_len_word = {8'h5A, 8'h00, 16'(r_len)};

    assign busy = (r_state != S_IDLE);
    assign done = r_done;

    // Frame sequencing: state, word/guard counter, captured length and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= payload_len;
                        r_cnt   <= '0;
                        r_state <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (w_out_hs) begin
                        if (r_cnt == PRE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_LENGTH;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LENGTH: begin
                    if (w_out_hs) begin
                        r_cnt <= '0;
                        if (r_len != '0) begin
                            r_state <= S_PAYLOAD;
                        end else begin
                            r_state <= S_GUARD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_out_hs) begin
                        if (r_cnt == w_pay_last) begin
                            r_cnt   <= '0;
                            r_state <= S_GUARD;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_GUARD: begin
                    // Lets the converter drain its final symbols before the next frame.
                    if (r_cnt == GUARD_LAST) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stream outputs decoded from state; payload is a zero-latency pass-through.
    always_comb begin
        axis_out_tdata  = '0;
        axis_out_tvalid = 1'b0;
        axis_pl_tready  = 1'b0;
        case (r_state)
            S_PREAMBLE: begin
                axis_out_tdata  = PREAMBLE_WORD;
                axis_out_tvalid = 1'b1;
            end
            S_LENGTH: begin
                axis_out_tdata  = w_len_word;
                axis_out_tvalid = 1'b1;
            end
            S_PAYLOAD: begin
                axis_out_tdata  = axis_pl_tdata;
                axis_out_tvalid = axis_pl_tvalid;
                axis_pl_tready  = axis_out_tready;
            end
            default: begin
                axis_out_tdata  = '0;
                axis_out_tvalid = 1'b0;
                axis_pl_tready  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_qpsk_tx_frame_ctrl.sv
// tb/tb_qpsk_tx_frame_ctrl.sv - randomized self-checking bench for qpsk_tx_frame_ctrl
module tb_qpsk_tx_frame_ctrl;

    localparam int          PL = 4;
    localparam int          GC = 16;
    localparam int          LW = 8;
    localparam logic [31:0] PW = 32'hCCCC_CCCC;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] payload_len;
    logic          busy;
    logic          done;
    logic [31:0]   pl_tdata;
    logic          pl_tvalid;
    logic          pl_tready;
    logic [31:0]   out_tdata;
    logic          out_tvalid;
    logic          out_tready;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    qpsk_tx_frame_ctrl #(
        .PREAMBLE_WORD (PW),
        .PREAMBLE_LEN  (PL),
        .LEN_W         (LW),
        .GUARD_CYCLES  (GC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .payload_len     (payload_len),
        .busy            (busy),
        .done            (done),
        .axis_pl_tdata   (pl_tdata),
        .axis_pl_tvalid  (pl_tvalid),
        .axis_pl_tready  (pl_tready),
        .axis_out_tdata  (out_tdata),
        .axis_out_tvalid (out_tvalid),
        .axis_out_tready (out_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One frame against a queue model of the expected output word stream.
    // rmode: 0 tready always, 1 tready 1-in-16, 2 random.  smode: 0 source always valid,
    // 1 alternating, 2 random.  poke: extra start during PREAMBLE.  abort_at: reset after
    // that many payload words (-1 = none).  Returns at the negedge of the done cycle.
    task automatic run_frame(input int len, input int rmode, input int smode,
                             input bit poke, input int abort_at);
        logic [31:0] exp_q[$];
        logic [31:0] pay[$];
        logic [31:0] w;
        logic [31:0] prev_data = '0;
        bit          stall_prev = 1'b0;
        int          oi = 0;
        int          pi = 0;
        int          gcnt = 0;
        int          bcnt = 0;
        int          total;
        for (int i = 0; i < PL; i++) exp_q.push_back(PW);
        exp_q.push_back({8'h5A, 8'h00, 16'(len)});
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            pay.push_back(w);
            exp_q.push_back(w);
        end
        total = PL + 1 + len;

        start       = 1'b1;
        payload_len = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;

        for (int n = 0; n < 5000; n++) begin
            case (rmode)
                0:       out_tready = 1'b1;
                1:       out_tready = ((cyc % 16) == 0);
                default: out_tready = 1'($urandom_range(0, 1));
            endcase
            if (pi < len) begin
                pl_tdata = pay[pi];
                case (smode)
                    0:       pl_tvalid = 1'b1;
                    1:       pl_tvalid = n[0];
                    default: pl_tvalid = 1'($urandom_range(0, 1));
                endcase
            end else begin
                pl_tdata  = $urandom;
                pl_tvalid = 1'b0;
            end
            if (poke && n == 2) begin
                start       = 1'b1;
                payload_len = 8'd7;
            end else begin
                start = 1'b0;
            end

            @(negedge clk);
            if (busy) bcnt++;
            if (n == 0) begin
                chk("first_busy", busy, 1);
                chk("first_tvalid", out_tvalid, 1);
            end
            if (stall_prev) begin
                chk("stall_hold_valid", out_tvalid, 1);
                chk("stall_hold_data", out_tdata, prev_data);
            end
            if (oi < PL + 1) begin
                chk("hdr_tvalid", out_tvalid, 1);
                chk("hdr_pl_tready", pl_tready, 0);
                chk("hdr_done", done, 0);
            end else if (oi < total) begin
                chk("pay_tvalid_mirror", out_tvalid, pl_tvalid);
                chk("pay_tready_mirror", pl_tready, out_tready);
                chk("pay_done", done, 0);
            end else if (done) begin
                chk("guard_cycles", gcnt, GC);
                chk("done_busy", busy, 0);
                chk("done_tvalid", out_tvalid, 0);
                if (rmode == 0 && smode == 0) chk("busy_cycles", bcnt, total + GC);
                start = 1'b0;
                return;
            end else begin
                chk("guard_tvalid", out_tvalid, 0);
                chk("guard_pl_tready", pl_tready, 0);
                chk("guard_busy", busy, 1);
                gcnt++;
            end
            stall_prev = out_tvalid && !out_tready && (oi < PL + 1);
            prev_data  = out_tdata;
            if (out_tvalid && out_tready && oi < total) begin
                chk($sformatf("word%0d", oi), out_tdata, exp_q[oi]);
                oi++;
            end
            if (pl_tvalid && pl_tready) pi++;

            @(posedge clk); #1;
            if (abort_at >= 0 && pi == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_tvalid", out_tvalid, 0);
                chk("abort_pl_tready", pl_tready, 0);
                chk("abort_done", done, 0);
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                end
                return;
            end
        end
        chk("frame_done_seen", done, 1);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_tvalid", out_tvalid, 0);
        chk("idle_tdata", out_tdata, 0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        payload_len = '0;
        pl_tdata    = '0;
        pl_tvalid   = 1'b0;
        out_tready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_pl_tready", pl_tready, 0);
        chk("rst_tdata", out_tdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_frame(3, 0, 0, 1'b0, -1);
        idle_check();
        run_frame(0, 0, 0, 1'b0, -1);
        idle_check();
        run_frame(8, 1, 0, 1'b0, -1);
        idle_check();
        run_frame(6, 0, 1, 1'b0, -1);
        idle_check();
        run_frame(5, 0, 0, 1'b1, -1);
        run_frame(2, 0, 0, 1'b0, -1);
        idle_check();
        repeat (3) idle_check();
        run_frame(5, 0, 0, 1'b0, 2);
        run_frame(1, 0, 0, 1'b0, -1);
        idle_check();
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(0, 20), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, -1);
            idle_check();
        end
        run_frame(255, 2, 2, 1'b0, -1);
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
